// File: rtl/text_pkg.sv
// Shared definitions for the text-mode character buffer controller.
package text_pkg;

  localparam int          TEXT_COLS       = 70;
  localparam int          TEXT_ROWS       = 30;
  localparam logic [7:0]  TEXT_ENTER_CODE = 8'hA9;
  localparam logic [7:0]  TEXT_BKSP_CODE  = 8'h08;
  localparam logic [7:0]  TEXT_BLANK      = 8'h20;

  typedef enum logic [1:0] {
    CLR_ALL = 2'd0,
    IDLE    = 2'd1,
    CLR_ROW = 2'd2
  } state_t;

  // Character memory cell address: row in the upper bits, column below.
  function automatic logic [11:0] make_addr(input logic [4:0] row, input logic [6:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/text_cursor.sv
// Cursor position register with step / newline / backspace / home commands.
// next_row/next_col expose the position the cursor takes at the next edge so
// the controller can address a backspace write at the new cell.
module text_cursor
  import text_pkg::*;
#(
  parameter int COLS = TEXT_COLS,
  parameter int ROWS = TEXT_ROWS
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       step,
  input  logic       newline,
  input  logic       bksp,
  input  logic       home,
  output logic [4:0] row,
  output logic [6:0] col,
  output logic [4:0] next_row,
  output logic [6:0] next_col,
  output logic       row_advanced
);

  localparam logic [6:0] COL_LAST = 7'(COLS - 1);
  localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);

  // Next cursor position; a row advance wraps from the last row to row 0.
  always_comb begin
    next_row     = row;
    next_col     = col;
    row_advanced = 1'b0;
    if (home) begin
      next_row = 5'd0;
      next_col = 7'd0;
    end else if (step) begin
      if (col < COL_LAST) begin
        next_col = col + 7'd1;
      end else begin
        next_col     = 7'd0;
        row_advanced = 1'b1;
      end
    end else if (newline) begin
      next_col     = 7'd0;
      row_advanced = 1'b1;
    end else if (bksp) begin
      if (col != 7'd0) begin
        next_col = col - 7'd1;
      end else if (row != 5'd0) begin
        next_row = row - 5'd1;
        next_col = COL_LAST;
      end
    end
    if (row_advanced) begin
      next_row = (row == ROW_LAST) ? 5'd0 : row + 5'd1;
    end
  end

  // Cursor register, homed by reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      row <= 5'd0;
      col <= 7'd0;
    end else begin
      row <= next_row;
      col <= next_col;
    end
  end

endmodule

// File: rtl/text_buf_ctrl.sv
// Text buffer sequencing controller: accepts ASCII codes, tracks the cursor,
// issues single-cell writes and runs full-screen / single-row blanking.
module text_buf_ctrl
  import text_pkg::*;
#(
  parameter int         COLS       = TEXT_COLS,
  parameter int         ROWS       = TEXT_ROWS,
  parameter logic [7:0] ENTER_CODE = TEXT_ENTER_CODE,
  parameter logic [7:0] BKSP_CODE  = TEXT_BKSP_CODE,
  parameter logic [7:0] BLANK      = TEXT_BLANK
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ch_valid,
  input  logic [7:0]  ch_code,
  output logic        ch_ready,
  input  logic        clr_screen,
  output logic        wr_en,
  output logic [11:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic [4:0]  cur_row,
  output logic [6:0]  cur_col,
  output logic        busy
);

  localparam logic [6:0] COL_LAST = 7'(COLS - 1);
  localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);

  state_t     state;
  logic [4:0] clr_row;
  logic [6:0] clr_col;

  logic       accept;
  logic       is_enter;
  logic       is_bksp;
  logic       is_print;
  logic       bksp_moves;
  logic       clr_all_last;
  logic       clr_col_last;
  logic       cmd_home;
  logic [4:0] next_row;
  logic [6:0] next_col;
  logic       row_advanced;

  assign ch_ready     = (state == IDLE) && !clr_screen;
  assign busy         = (state != IDLE);
  assign accept       = ch_valid && ch_ready;

  assign is_enter     = (ch_code == ENTER_CODE);
  assign is_bksp      = (ch_code == BKSP_CODE) && !is_enter;
  assign is_print     = (ch_code >= 8'h20) && (ch_code <= 8'h7E) && !is_enter && !is_bksp;
  assign bksp_moves   = (cur_row != 5'd0) || (cur_col != 7'd0);

  assign clr_col_last = (clr_col == COL_LAST);
  assign clr_all_last = clr_col_last && (clr_row == ROW_LAST);
  assign cmd_home     = (state == CLR_ALL) && clr_all_last;

  text_cursor #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_cursor (
    .clk          (clk),
    .resetn       (resetn),
    .step         (accept && is_print),
    .newline      (accept && is_enter),
    .bksp         (accept && is_bksp),
    .home         (cmd_home),
    .row          (cur_row),
    .col          (cur_col),
    .next_row     (next_row),
    .next_col     (next_col),
    .row_advanced (row_advanced)
  );

  // Sequencer: clear sweeps issue one BLANK write per cycle; in IDLE an
  // accepted code produces at most one write on the following cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= CLR_ALL;
      clr_row <= 5'd0;
      clr_col <= 7'd0;
      wr_en   <= 1'b0;
      wr_addr <= 12'd0;
      wr_data <= 8'd0;
    end else begin
      case (state)
        CLR_ALL: begin
          wr_en   <= 1'b1;
          wr_addr <= make_addr(clr_row, clr_col);
          wr_data <= BLANK;
          if (clr_col_last) begin
            clr_col <= 7'd0;
            if (clr_row == ROW_LAST) begin
              clr_row <= 5'd0;
              state   <= IDLE;
            end else begin
              clr_row <= clr_row + 5'd1;
            end
          end else begin
            clr_col <= clr_col + 7'd1;
          end
        end
        CLR_ROW: begin
          wr_en   <= 1'b1;
          wr_addr <= make_addr(cur_row, clr_col);
          wr_data <= BLANK;
          if (clr_col_last) begin
            clr_col <= 7'd0;
            state   <= IDLE;
          end else begin
            clr_col <= clr_col + 7'd1;
          end
        end
        IDLE: begin
          wr_en <= 1'b0;
          if (clr_screen) begin
            state   <= CLR_ALL;
            clr_row <= 5'd0;
            clr_col <= 7'd0;
          end else if (accept) begin
            if (is_print) begin
              wr_en   <= 1'b1;
              wr_addr <= make_addr(cur_row, cur_col);
              wr_data <= ch_code;
            end else if (is_bksp && bksp_moves) begin
              wr_en   <= 1'b1;
              wr_addr <= make_addr(next_row, next_col);
              wr_data <= BLANK;
            end
            if (row_advanced) begin
              state   <= CLR_ROW;
              clr_col <= 7'd0;
            end
          end
        end
        default: begin
          state   <= CLR_ALL;
          clr_row <= 5'd0;
          clr_col <= 7'd0;
          wr_en   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_buf_ctrl.sv
// Self-checking bench for text_buf_ctrl: directed steps plus random codes,
// checked against a screen/cursor reference model.
module tb_text_buf_ctrl;
  import text_pkg::*;

  localparam int COLS  = 70;
  localparam int ROWS  = 30;
  localparam int NCELL = COLS * ROWS;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ch_valid = 1'b0;
  logic [7:0]  ch_code = 8'd0;
  logic        clr_screen = 1'b0;
  logic        ch_ready;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic [4:0]  cur_row;
  logic [6:0]  cur_col;
  logic        busy;

  text_buf_ctrl dut (
    .clk        (clk),
    .resetn     (resetn),
    .ch_valid   (ch_valid),
    .ch_code    (ch_code),
    .ch_ready   (ch_ready),
    .clr_screen (clr_screen),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cur_row    (cur_row),
    .cur_col    (cur_col),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int bad_addr = 0;
  int base;

  typedef struct {
    int addr;
    int data;
    int off;
  } wr_t;

  wr_t log_q[$];
  wr_t exp_q[$];
  logic [7:0] shadow [NCELL];
  logic [7:0] model_scr [NCELL];
  int m_row;
  int m_col;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every DUT write mid-cycle into a log and a shadow screen.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      log_q.push_back('{int'(wr_addr), int'(wr_data), cyc});
      if (int'(wr_addr[6:0]) < COLS && int'(wr_addr[11:7]) < ROWS)
        shadow[int'(wr_addr[11:7]) * COLS + int'(wr_addr[6:0])] = wr_data;
      else
        bad_addr++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void push_exp(input int r, input int c, input int d, input int off);
    exp_q.push_back('{r * 128 + c, d, off});
    model_scr[r * COLS + c] = 8'(d);
  endfunction

  // Reference: what one accepted code does to the screen and cursor.
  function automatic void model_char(input int code);
    bit adv = 1'b0;
    exp_q.delete();
    if (code == 'hA9) begin
      m_col = 0;
      adv = 1'b1;
    end else if (code == 'h08) begin
      if (m_col > 0) begin
        m_col--;
        push_exp(m_row, m_col, 'h20, 0);
      end else if (m_row > 0) begin
        m_row--;
        m_col = COLS - 1;
        push_exp(m_row, m_col, 'h20, 0);
      end
    end else if (code >= 'h20 && code <= 'h7E) begin
      push_exp(m_row, m_col, code, 0);
      if (m_col < COLS - 1) m_col++;
      else begin
        m_col = 0;
        adv = 1'b1;
      end
    end
    if (adv) begin
      m_row = (m_row + 1) % ROWS;
      for (int k = 0; k < COLS; k++) push_exp(m_row, k, 'h20, k + 1);
    end
  endfunction

  function automatic void model_clear_all(input int first_off);
    exp_q.delete();
    for (int i = 0; i < NCELL; i++) push_exp(i / COLS, i % COLS, 'h20, first_off + i);
    m_row = 0;
    m_col = 0;
  endfunction

  task automatic wait_idle(input string tag, input int limit);
    int n = 0;
    while (busy !== 1'b0 && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_idle"}, busy, 0);
    @(negedge clk);
    #1;
  endtask

  task automatic compare_log(input string tag);
    int mism = 0;
    chk({tag, "_count"}, log_q.size(), exp_q.size());
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
      if (log_q[i].addr != exp_q[i].addr || log_q[i].data != exp_q[i].data ||
          log_q[i].off - base != exp_q[i].off)
        mism++;
    end
    chk({tag, "_writes"}, mism, 0);
  endtask

  task automatic send(input logic [7:0] code);
    int n = 0;
    bit clr_exp;
    bit imm_exp;
    while (ch_ready !== 1'b1 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ready_wait", ch_ready, 1);
    model_char(int'(code));
    imm_exp = (exp_q.size() > 0) && (exp_q[0].off == 0);
    clr_exp = (exp_q.size() > 0) && (exp_q[exp_q.size() - 1].off > 0);
    log_q.delete();
    ch_valid = 1'b1;
    ch_code  = code;
    @(posedge clk);
    #1;
    ch_valid = 1'b0;
    base = cyc;
    chk("wr_en_next", wr_en, imm_exp);
    chk("cur_row", cur_row, m_row);
    chk("cur_col", cur_col, m_col);
    chk("ready_after", ch_ready, !clr_exp);
    wait_idle("char", 300);
    compare_log("char");
    $display("txn code=%02h cursor=(%0d,%0d) writes=%0d", code, cur_row, cur_col, log_q.size());
  endtask

  function automatic logic [7:0] rand_code();
    int p = $urandom_range(0, 99);
    if (p < 70) return 8'($urandom_range(32, 126));
    if (p < 78) return 8'hA9;
    if (p < 93) return 8'h08;
    return 8'($urandom_range(0, 31));
  endfunction

  initial begin
    for (int i = 0; i < NCELL; i++) begin
      shadow[i]    = 8'h00;
      model_scr[i] = 8'h00;
    end
    m_row = 0;
    m_col = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 1);
    chk("rst_ready", ch_ready, 0);
    chk("rst_row", cur_row, 0);
    chk("rst_col", cur_col, 0);

    // Power-up clear
    log_q.delete();
    resetn = 1'b1;
    @(posedge clk);
    #1;
    base = cyc;
    chk("clr_first_en", wr_en, 1);
    chk("clr_first_addr", wr_addr, 0);
    chk("clr_first_data", wr_data, 8'h20);
    model_clear_all(0);
    wait_idle("clr_all", 2300);
    compare_log("clr_all");
    if (log_q.size() > 0) chk("clr_last_addr", log_q[log_q.size() - 1].addr, 'hEC5);
    chk("clr_ready", ch_ready, 1);
    chk("clr_row", cur_row, 0);
    chk("clr_col", cur_col, 0);
    $display("txn power-up clear writes=%0d", log_q.size());

    // Directed characters
    send(8'h41);
    chk("A_col", cur_col, 1);
    for (int i = 0; i < 68; i++) send(8'($urandom_range(32, 126)));
    chk("eol_col", cur_col, 69);
    send(8'h42);
    chk("wrap_row", cur_row, 1);
    chk("wrap_col", cur_col, 0);
    repeat (28) send(8'hA9);
    repeat (5) send(8'($urandom_range(32, 126)));
    chk("pos29_row", cur_row, 29);
    send(8'hA9);
    chk("wrap0_row", cur_row, 0);
    chk("wrap0_col", cur_col, 0);
    repeat (3) send(8'hA9);
    send(8'h08);
    chk("bksp_row", cur_row, 2);
    chk("bksp_col", cur_col, 69);

    // clr_screen wins over a coincident character
    log_q.delete();
    clr_screen = 1'b1;
    ch_valid   = 1'b1;
    ch_code    = 8'h41;
    #1;
    chk("clr_ready_low", ch_ready, 0);
    @(posedge clk);
    #1;
    clr_screen = 1'b0;
    ch_valid   = 1'b0;
    base = cyc;
    chk("clr_req_busy", busy, 1);
    model_clear_all(1);
    wait_idle("clr_req", 2300);
    compare_log("clr_req");
    chk("clr_req_row", cur_row, 0);
    chk("clr_req_col", cur_col, 0);
    $display("txn clr_screen writes=%0d", log_q.size());

    // Codes that must not write or move
    send(8'h08);
    send(8'h00);
    send(8'h90);
    chk("nop_col", cur_col, 0);

    // Random codes
    for (int t = 0; t < 300; t++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send(rand_code());
    end

    // Reset in the middle of a row clear
    send(8'h41);
    ch_valid = 1'b1;
    ch_code  = 8'hA9;
    @(posedge clk);
    #1;
    ch_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("midclr_busy", busy, 1);
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_wr_en", wr_en, 0);
    chk("midrst_row", cur_row, 0);
    log_q.delete();
    resetn = 1'b1;
    @(posedge clk);
    #1;
    base = cyc;
    chk("restart_en", wr_en, 1);
    chk("restart_addr", wr_addr, 0);
    model_clear_all(0);
    wait_idle("restart", 2300);
    compare_log("restart");
    chk("restart_row", cur_row, 0);
    chk("restart_col", cur_col, 0);
    $display("txn reset mid-clear writes=%0d", log_q.size());

    // Final screen contents and address range
    begin
      int diff = 0;
      for (int i = 0; i < NCELL; i++) if (shadow[i] !== model_scr[i]) diff++;
      chk("screen", diff, 0);
    end
    chk("bad_addr", bad_addr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
